// File: rtl/m_seq_gen.sv
// m_seq_gen: parametrised Fibonacci-LFSR m-sequence source with free-run/burst modes,
// valid/ready output, period-start marker and zero-seed lockup protection.
module m_seq_gen #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(4'b1001),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(4'b1001),
  parameter int BLW = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_mode,
  input  logic             i_en,
  input  logic             i_start,
  input  logic [BLW-1:0]   i_burst_len,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_seed_in,
  input  logic             i_data_rdy,
  output logic             o_data_out,
  output logic             o_data_vld,
  output logic             o_seq_start,
  output logic             o_busy,
  output logic             o_lockup
);
  typedef enum logic {S_IDLE, S_RUN} state_t;
  localparam logic [WIDTH-1:0] PMAX = WIDTH'((64'd1 << WIDTH) - 64'd2);
  state_t           r_fsm, w_fsm_nxt;
  logic [WIDTH-1:0] r_lfsr, r_phase;
  logic [BLW-1:0]   r_rem;
  logic             r_mode, r_out, r_vld, r_ss, r_lockup;
  logic             w_idle, w_want, w_free, w_issue, w_trig, w_fb;
  assign w_idle  = r_fsm == S_IDLE;
  assign w_want  = r_mode ? (r_rem != '0) : i_en;
  assign w_free  = !r_vld || i_data_rdy;
  assign w_issue = !w_idle && w_free && w_want;
  // a load in IDLE takes precedence over any trigger in the same cycle
  assign w_trig  = !i_load && (i_mode ? (i_start && i_burst_len != '0) : i_en);
  assign w_fb    = ^(r_lfsr & POLY);
  always_comb begin
    w_fsm_nxt = w_idle ? (w_trig ? S_RUN : S_IDLE) : ((!w_want && w_free) ? S_IDLE : S_RUN);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fsm    <= S_IDLE;
      r_lfsr   <= SEED;
      r_phase  <= '0;
      r_rem    <= '0;
      r_mode   <= 1'b0;
      r_out    <= 1'b0;
      r_vld    <= 1'b0;
      r_ss     <= 1'b0;
      r_lockup <= 1'b0;
    end else begin
      r_fsm    <= w_fsm_nxt;
      r_lockup <= w_idle && i_load && i_seed_in == '0;
      if (w_idle && i_load) begin
        r_lfsr  <= (i_seed_in == '0) ? SEED : i_seed_in;
        r_phase <= '0;
      end else if (w_issue) begin
        r_lfsr  <= {r_lfsr[WIDTH-2:0], w_fb};
        r_phase <= (r_phase == PMAX) ? '0 : r_phase + WIDTH'(1);
      end
      if (w_idle && w_trig) begin
        r_mode <= i_mode;
        r_rem  <= i_burst_len;
      end else if (w_issue && r_mode) begin
        r_rem <= r_rem - BLW'(1);
      end
      if (w_issue) begin
        r_out <= r_lfsr[WIDTH-1];
        r_ss  <= r_phase == '0;
        r_vld <= 1'b1;
      end else if (i_data_rdy) begin
        r_vld <= 1'b0;
        r_ss  <= 1'b0;
      end
    end
  end
  assign o_data_out  = r_out;
  assign o_data_vld  = r_vld;
  assign o_seq_start = r_ss;
  assign o_busy      = r_fsm == S_RUN;
  assign o_lockup    = r_lockup;
endmodule

// File: tb/tb_m_seq_gen.sv
// tb_m_seq_gen: directed scenarios with a transfer-level sequence model for m_seq_gen.
module tb_m_seq_gen;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        mode = 1'b0, en = 1'b0, start = 1'b0, load = 1'b0, rdy = 1'b1;
  logic [15:0] blen = '0;
  logic [3:0]  seed = '0;
  logic        dout, vld, ss, busy, lockup;
  int          nvec = 0, nerr = 0;
  int          pos = 0, ph = 0;
  bit          cap[$], cap_ss[$];
  bit          prev_stall = 0, prev_out = 0;
  logic [14:0] seq_lit = 15'b100100011110101;
  int          st_tab[15] = '{9, 2, 4, 8, 1, 3, 7, 15, 14, 13, 10, 5, 11, 6, 12};

  m_seq_gen dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_en(en), .i_start(start),
    .i_burst_len(blen), .i_load(load), .i_seed_in(seed), .i_data_rdy(rdy),
    .o_data_out(dout), .o_data_vld(vld), .o_seq_start(ss), .o_busy(busy), .o_lockup(lockup)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [3:0] s);
    for (int i = 0; i < 15; i++) if (st_tab[i] == int'(s)) return i;
    return 0;
  endfunction

  function automatic logic [31:0] bits_of(input int first, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = (v << 1) | 32'(cap[first + i]);
    return v;
  endfunction

  // every accepted bit must be the next m-sequence bit; stalled bits must hold
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      if (prev_stall) begin
        check("hold_vld", 32'(vld), 32'd1);
        check("hold_data", 32'(dout), 32'(prev_out));
      end
      if (vld && rdy) begin
        check("data", 32'(dout), 32'(seq_lit[14 - pos]));
        check("seq_start", 32'(ss), 32'(ph == 0));
        cap.push_back(dout);
        cap_ss.push_back(ss);
        pos = (pos + 1) % 15;
        ph  = (ph + 1) % 15;
      end
      prev_stall = vld && !rdy;
      prev_out   = dout;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string nm);
    check(nm, {27'd0, dout, vld, ss, busy, lockup}, 32'd0);
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 300 && busy; i++) tick();
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_bits(input int n);
    for (int i = 0; i < 300 && cap.size() < n; i++) tick();
    check("bits_timeout", 32'(cap.size() >= n), 32'd1);
  endtask

  task automatic do_load(input logic [3:0] s);
    load = 1'b1;
    seed = s;
    tick();
    load = 1'b0;
    pos = idx_of(s == 4'd0 ? 4'd9 : s);
    ph  = 0;
    check("lockup_pulse", 32'(lockup), 32'(s == 4'd0));
    tick();
    check("lockup_clear", 32'(lockup), 32'd0);
  endtask

  task automatic burst(input int n);
    mode = 1'b1;
    blen = 16'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic free_run(input int n);
    mode = 1'b0;
    en = 1'b1;
    wait_bits(n);
    en = 1'b0;
    wait_idle();
  endtask

  initial begin
    #2;
    check_zero("reset_outputs");
    // 1: free-run from reset
    mode = 1'b0; en = 1'b1; rdy = 1'b1;
    tick();
    rst_n = 1'b1;
    wait_bits(31);
    en = 1'b0;
    wait_idle();
    check("s1_period1", bits_of(0, 15), 32'h48F5);
    check("s1_period2", bits_of(15, 15), 32'h48F5);
    check("s1_ss", {29'd0, cap_ss[0], cap_ss[15], cap_ss[30]}, 32'd7);
    check("s1_ss_count", 32'(cap_ss.sum() with (int'(item))), 32'(1 + (cap.size() - 1) / 15));
    // 2: bursts, latency, ignored zero-length start, ignored load in RUN
    do_load(4'b1001);
    cap.delete(); cap_ss.delete();
    burst(5);
    check("s2_busy_entry", 32'(busy), 32'd1);
    check("s2_vld_not_yet", 32'(vld), 32'd0);
    tick();
    check("s2_first_vld", 32'(vld), 32'd1);
    wait_idle();
    check("s2_count1", 32'(cap.size()), 32'd5);
    check("s2_bits1", bits_of(0, 5), 32'b10010);
    burst(0);
    tick();
    check("s2_zero_len", 32'(busy), 32'd0);
    burst(5);
    load = 1'b1; seed = 4'b0001;
    tick();
    load = 1'b0;
    wait_idle();
    check("s2_count2", 32'(cap.size()), 32'd10);
    check("s2_bits2", bits_of(5, 5), 32'b00111);
    // 3: back-pressure
    do_load(4'b1001);
    cap.delete(); cap_ss.delete();
    mode = 1'b0; en = 1'b1;
    for (int i = 0; i < 48; i++) begin
      rdy = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    en = 1'b0; rdy = 1'b1;
    wait_idle();
    check("s3_enough", 32'(cap.size() >= 15), 32'd1);
    check("s3_bits", bits_of(0, 15), 32'h48F5);
    // 4: load of a nonzero seed
    do_load(4'b0001);
    cap.delete(); cap_ss.delete();
    free_run(16);
    check("s4_bits", bits_of(0, 16), 32'b0001111010110010);
    check("s4_ss_first", 32'(cap_ss[0]), 32'd1);
    // 5: zero seed falls back to SEED
    do_load(4'b0000);
    cap.delete(); cap_ss.delete();
    free_run(15);
    check("s5_bits", bits_of(0, 15), 32'h48F5);
    check("s5_ss_first", 32'(cap_ss[0]), 32'd1);
    // 6: async reset mid-burst
    do_load(4'b1001);
    cap.delete(); cap_ss.delete();
    burst(10);
    wait_bits(3);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("s6_reset_now");
    pos = 0; ph = 0;
    tick();
    check_zero("s6_reset_hold");
    rst_n = 1'b1;
    cap.delete(); cap_ss.delete();
    tick();
    burst(3);
    wait_idle();
    check("s6_count", 32'(cap.size()), 32'd3);
    check("s6_bits", bits_of(0, 3), 32'b100);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
